// File: rtl/serdes_pkg.sv
// Shared definitions for the safe-datapath serializer/deserializer pair.
package serdes_pkg;

    // Default word width of the code path between p2s and s2p_deser.
    localparam int WORD_W = 4;

    // Deserializer buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        HAVE_OUT = 2'd1,
        FULL     = 2'd2
    } s2p_state_t;

endpackage

// File: rtl/s2p_deser.sv
// Serial-to-parallel deserializer: collects an LSB-first serial stream into
// N-bit words and presents them on a parallel valid/ready interface. The
// assembly shift register and the output register form a two-word buffer,
// so the next word can be collected while the current one waits.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   EMPTY    | no word presented; sh_reg may hold a partial word
//   HAVE_OUT | out_reg presented; sh_reg assembling the next word
//   FULL     | out_reg presented; sh_reg holds a complete word, stall
module s2p_deser
    import serdes_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ser_valid,
    input  logic         ser_data,
    output logic         ser_ready,
    output logic         par_valid,
    output logic [N-1:0] par_data,
    input  logic         par_ready
);

    localparam int CW = $clog2(N);
    // Explicit terminal count so non-power-of-2 widths never wrap by overflow.
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    s2p_state_t    state;
    logic [N-1:0]  sh_reg;
    logic [N-1:0]  out_reg;
    logic [CW-1:0] bit_cnt;

    logic          ser_xfer;
    logic          par_xfer;
    logic          word_done;
    logic [N-1:0]  new_word;

    // Output decode straight from registered state.
    assign par_valid = (state != EMPTY);
    assign ser_ready = (state != FULL);
    assign par_data  = out_reg;

    assign ser_xfer  = ser_valid && ser_ready;
    assign par_xfer  = par_valid && par_ready;
    assign new_word  = {ser_data, sh_reg[N-1:1]};
    assign word_done = ser_xfer && (bit_cnt == CNT_MAX);

    // Shift-in datapath, bit counter and buffer-occupancy controller.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= EMPTY;
            sh_reg  <= '0;
            out_reg <= '0;
            bit_cnt <= '0;
        end else begin
            if (ser_xfer) begin
                sh_reg  <= new_word;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end

            case (state)
                EMPTY: begin
                    if (word_done) begin
                        out_reg <= new_word;
                        state   <= HAVE_OUT;
                    end
                end
                HAVE_OUT: begin
                    if (word_done && par_xfer) begin
                        // Drain and refill on the same edge: no bubble.
                        out_reg <= new_word;
                    end else if (word_done) begin
                        // sh_reg keeps the completed word until out_reg frees.
                        state <= FULL;
                    end else if (par_xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // ser_ready is low here, so sh_reg is not shifting.
                    if (par_xfer) begin
                        out_reg <= sh_reg;
                        sh_reg  <= '0;
                        state   <= HAVE_OUT;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // The buffer never accepts a serial bit while both words are occupied.
    a_no_ser_in_full: assert property (
        @(posedge clk) disable iff (!rstn)
        (state == FULL) |-> !(ser_valid && ser_ready)
    );

    // A presented word stays valid and unchanged until it is taken.
    a_par_stable: assert property (
        @(posedge clk) disable iff (!rstn)
        (par_valid && !par_ready) |=> (par_valid && $stable(par_data))
    );

endmodule

// File: tb/tb_s2p_deser.sv
// Self-checking bench for s2p_deser: directed scenarios plus a random
// serializer loopback, all checked through an expected-word queue.
module tb_s2p_deser;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         ser_valid;
    logic         ser_data;
    logic         ser_ready;
    logic         par_valid;
    logic [N-1:0] par_data;
    logic         par_ready;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           stalls   = 0;
    int           rx_cnt   = 0;
    bit           lb_done;
    logic [N-1:0] sb[$];

    s2p_deser #(.N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .par_valid (par_valid),
        .par_data  (par_data),
        .par_ready (par_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int n;
        ser_valid = 1'b1;
        ser_data  = b;
        n = 0;
        while (!ser_ready && n < 200) begin
            stalls++;
            tick();
            n++;
        end
        if (n >= 200) chk("ser_ready_timeout", 32'd0, 32'd1);
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input int gaps);
        sb.push_back(w);
        for (int i = 0; i < N; i++) begin
            if (gaps > 0) repeat ($urandom_range(0, gaps)) tick();
            send_bit(w[i]);
        end
    endtask

    task automatic drain();
        int n;
        par_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
        tick();
    endtask

    initial begin
        logic [N-1:0] w;

        rstn      = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        par_ready = 1'b0;

        // Watchdog and output monitor (sample on negedge, transfer at next posedge).
        fork
            begin
                #400000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
            forever begin
                @(negedge clk);
                if (rstn && par_valid && par_ready) begin
                    rx_cnt++;
                    if (sb.size() == 0) chk("unexpected_word", 32'(par_data), 32'hFFFF);
                    else chk("par_data", 32'(par_data), 32'(sb.pop_front()));
                end
            end
        join_none

        #12;
        chk("rst_par_valid", 32'(par_valid), 32'd0);
        chk("rst_par_data", 32'(par_data), 32'd0);
        chk("rst_ser_ready", 32'(ser_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // 1: basic word 4'hA, bits 0,1,0,1
        par_ready = 1'b1;
        send_word(4'hA, 0);
        chk("t1_valid", 32'(par_valid), 32'd1);
        chk("t1_data", 32'(par_data), 32'hA);
        tick();
        chk("t1_valid_drop", 32'(par_valid), 32'd0);

        // 2: backpressure, 4'h3 then 4'hC continuous
        par_ready = 1'b0;
        send_word(4'h3, 0);
        send_word(4'hC, 0);
        chk("t2_ser_ready_low", 32'(ser_ready), 32'd0);
        chk("t2_held_data", 32'(par_data), 32'h3);
        repeat (3) tick();
        chk("t2_still_held", 32'(par_data), 32'h3);
        chk("t2_still_valid", 32'(par_valid), 32'd1);
        par_ready = 1'b1;
        tick();
        chk("t2_second_word", 32'(par_data), 32'hC);
        chk("t2_ser_ready_back", 32'(ser_ready), 32'd1);
        tick();
        chk("t2_empty", 32'(par_valid), 32'd0);

        // 3: drain and completion on the same edge
        par_ready = 1'b0;
        send_word(4'h9, 0);
        stalls = 0;
        sb.push_back(4'h5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        par_ready = 1'b1;
        send_bit(1'b0);
        chk("t3_valid", 32'(par_valid), 32'd1);
        chk("t3_data", 32'(par_data), 32'h5);
        chk("t3_no_stall", 32'(stalls), 32'd0);
        chk("t3_ser_ready", 32'(ser_ready), 32'd1);
        tick();
        chk("t3_empty", 32'(par_valid), 32'd0);

        // 4: 4'hE with random idle gaps between bits
        rx_cnt = 0;
        send_word(4'hE, 3);
        repeat (4) tick();
        chk("t4_word_count", 32'(rx_cnt), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5a: reset while FULL with a stalled bit offered
        par_ready = 1'b0;
        send_word(4'hA, 0);
        send_word(4'hB, 0);
        chk("t5_full", 32'(ser_ready), 32'd0);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        #3 rstn = 1'b0;
        #1;
        chk("t5_rst_par_valid", 32'(par_valid), 32'd0);
        chk("t5_rst_par_data", 32'(par_data), 32'd0);
        chk("t5_rst_ser_ready", 32'(ser_ready), 32'd1);
        sb.delete();
        ser_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        // 5b: reset after 2 partial bits, then 4'h6 must come out alone
        send_bit(1'b1);
        send_bit(1'b1);
        #3 rstn = 1'b0;
        #1;
        chk("t5b_rst_par_valid", 32'(par_valid), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        rx_cnt = 0;
        par_ready = 1'b1;
        send_word(4'h6, 0);
        repeat (3) tick();
        chk("t5_word_count", 32'(rx_cnt), 32'd1);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // 6: loopback from a serializer model, random par_ready
        rx_cnt  = 0;
        lb_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 64; k++) begin
                    w = N'($urandom_range(0, (1 << N) - 1));
                    send_word(w, 2);
                end
                lb_done = 1'b1;
            end
            begin
                while (!lb_done) begin
                    par_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();
        chk("t6_word_count", 32'(rx_cnt), 32'd64);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_final_valid", 32'(par_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
